// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V control FSM with ALU and immediate decoders
// Optional MULTICYCLE_BNE_EN: BEQ state also resolves bne (f3=001) as a taken-on-nonzero branch.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       f7,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regWrite,
   output logic [1:0] resSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] inmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] w_alu_op;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_take;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_FETCH;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Reset presents FETCH mux selects but suppresses every write enable.
   always_comb begin
      adrSrc      = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regWrite    = 1'b0;
      resSrc      = 2'b00;
      aluSrcA     = 2'b00;
      aluSrcB     = 2'b00;
      w_alu_op    = 2'b00;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      if (reset) begin
         aluSrcB = 2'b10;
         resSrc  = 2'b10;
      end else begin
         case (r_state)
            S_FETCH: begin
               irWrite     = 1'b1;
               aluSrcB     = 2'b10;
               resSrc      = 2'b10;
               w_pc_update = 1'b1;
            end
            S_DECODE: begin
               aluSrcA = 2'b01;
               aluSrcB = 2'b01;
            end
            S_MEMADR: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
               resSrc   = 2'b01;
               regWrite = 1'b1;
            end
            S_MEMWRITE: begin
               adrSrc   = 1'b1;
               memWrite = 1'b1;
            end
            S_EXECUTER: begin
               aluSrcA  = 2'b10;
               w_alu_op = 2'b10;
            end
            S_EXECUTEI: begin
               aluSrcA  = 2'b10;
               aluSrcB  = 2'b01;
               w_alu_op = 2'b10;
            end
            S_ALUWB: regWrite = 1'b1;
            S_JAL: begin
               aluSrcA     = 2'b01;
               aluSrcB     = 2'b10;
               w_pc_update = 1'b1;
            end
            S_BEQ: begin
               aluSrcA  = 2'b10;
               w_alu_op = 2'b01;
               w_branch = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MULTICYCLE_BNE_EN
   always_comb begin
      case (f3)
         3'b000:  w_take = zero;
         3'b001:  w_take = ~zero;
         default: w_take = 1'b0;
      endcase
   end
`else
   assign w_take = zero;
`endif

   assign pcWrite = w_pc_update | (w_branch & w_take);

   always_comb begin
      case (op)
         OP_SW:   inmSrc = 2'b01;
         OP_BEQ:  inmSrc = 2'b10;
         OP_JAL:  inmSrc = 2'b11;
         default: inmSrc = 2'b00;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (w_alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (f3)
               3'b000:  ALUControl = ({op[5], f7} == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with instruction-level reference model
module tb_multicycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] res;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] inm;
      logic [2:0] alu;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7;
   logic       zero;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
   logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   vec_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
      .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
      .regWrite(regWrite), .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .inmSrc(inmSrc), .ALUControl(ALUControl), .state(state)
   );

   // Instruction class -> sequence of states it walks through, starting at FETCH.
   function automatic void inst_path(input logic [6:0] o, output int p[5], output int n);
      p = '{0, 1, 0, 0, 0};
      n = 2;
      if (o == 7'b0000011) begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
      else if (o == 7'b0100011) begin p[2] = 2; p[3] = 5; n = 4; end
      else if (o == 7'b0110011) begin p[2] = 6; p[3] = 7; n = 4; end
      else if (o == 7'b0010011) begin p[2] = 8; p[3] = 7; n = 4; end
      else if (o == 7'b1101111) begin p[2] = 9; p[3] = 7; n = 4; end
      else if (o == 7'b1100011) begin p[2] = 10; n = 3; end
   endfunction

   function automatic logic [1:0] imm_sel(input logic [6:0] o);
      if (o == 7'b0100011) return 2'b01;
      if (o == 7'b1100011) return 2'b10;
      if (o == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [2:0] alu_arith(input logic [6:0] o, input logic [2:0] ff3, input logic ff7);
      if (ff3 == 3'd0) return (o[5] && ff7) ? 3'b001 : 3'b000;
      if (ff3 == 3'd2) return 3'b101;
      if (ff3 == 3'd6) return 3'b011;
      if (ff3 == 3'd7) return 3'b010;
      return 3'b000;
   endfunction

   function automatic logic branch_taken(input logic [2:0] ff3, input logic z);
`ifdef MULTICYCLE_BNE_EN
      if (ff3 == 3'd0) return z;
      if (ff3 == 3'd1) return !z;
      return 1'b0;
`else
      return z;
`endif
   endfunction

   function automatic vec_t expect_out(input int s, input logic [6:0] o, input logic [2:0] ff3,
                                       input logic ff7, input logic z, input bit rst);
      vec_t v;
      v = '0;
      v.st  = 4'(s);
      v.inm = imm_sel(o);
      if (rst) begin
         v.res = 2'b10;
         v.b   = 2'b10;
         return v;
      end
      case (s)
         0:  begin v.irw = 1; v.pcw = 1; v.b = 2'b10; v.res = 2'b10; end
         1:  begin v.a = 2'b01; v.b = 2'b01; end
         2:  begin v.a = 2'b10; v.b = 2'b01; end
         3:  v.adr = 1;
         4:  begin v.res = 2'b01; v.rw = 1; end
         5:  begin v.adr = 1; v.mw = 1; end
         6:  begin v.a = 2'b10; v.alu = alu_arith(o, ff3, ff7); end
         7:  v.rw = 1;
         8:  begin v.a = 2'b10; v.b = 2'b01; v.alu = alu_arith(o, ff3, ff7); end
         9:  begin v.a = 2'b01; v.b = 2'b10; v.pcw = 1; end
         10: begin v.a = 2'b10; v.alu = 3'b001; v.pcw = branch_taken(ff3, z); end
         default: ;
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rst_at: index within the instruction's state sequence where reset strikes, -1 for none.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] ff3, input logic ff7,
                            input logic z, input int rst_at);
      int p[5];
      int n;
      op = o; f3 = ff3; f7 = ff7; zero = z;
      inst_path(o, p, n);
      for (int i = 0; i < n; i++) begin
         if (i == rst_at) begin
            reset = 1'b1;
            q.push_back(expect_out(p[i], o, ff3, ff7, z, 1'b1));
            tick();
            reset = 1'b0;
            return;
         end
         q.push_back(expect_out(p[i], o, ff3, ff7, z, 1'b0));
         tick();
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         vec_t act;
         vec_t e;
         act = '{state, pcWrite, adrSrc, memWrite, irWrite, regWrite,
                 resSrc, aluSrcA, aluSrcB, inmSrc, ALUControl};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL underflow cyc=%0d: DUT output %b with no expected entry", cyc, act);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL cyc=%0d ctrl: got st=%0d pcw/adr/mw/irw/rw=%b res/a/b/inm=%b alu=%b, want st=%0d pcw/adr/mw/irw/rw=%b res/a/b/inm=%b alu=%b",
                        cyc, act.st, {act.pcw, act.adr, act.mw, act.irw, act.rw},
                        {act.res, act.a, act.b, act.inm}, act.alu,
                        e.st, {e.pcw, e.adr, e.mw, e.irw, e.rw}, {e.res, e.a, e.b, e.inm}, e.alu);
            end
         end
         cyc++;
      end
   end

   logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100011, 7'b1111111};

   initial begin
      logic [6:0] o;
      int idx;
      int rst_at;
      reset = 1'b1; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
      tick();
      mon_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         q.push_back(expect_out(0, op, f3, f7, zero, 1'b1));
         tick();
      end
      reset = 1'b0;

      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1);
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1);
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b1, -1);
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1);
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1);
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, -1);
      run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, -1);
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2);
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1);
      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1);
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, -1);
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 4);

      for (int k = 0; k < 300; k++) begin
         idx = $urandom_range(0, 7);
         if (idx == 7) o = 7'($urandom);
         else o = ops[idx];
         rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
         run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), rst_at);
      end

      @(negedge clk);
      mon_en = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
